axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
AXI4 memory slave that answers the bus master's write and read bursts from an internal word-addressed RAM.
Write and read channels run independent FSMs, each handling one outstanding transaction.
INCR bursts up to 256 beats are supported, with per-beat address checking.
Used as the bench target and on-chip scratch memory for the master.

Parameters:
ID_WIDTH, 4, width of AWID/BID/ARID/RID
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; DATA_WIDTH/8 strobe bits; beat size fixed at DATA_WIDTH/8 bytes
DEPTH, 1024, RAM words; valid byte range 0 .. DEPTH*(DATA_WIDTH/8)-1

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
S_AXI_AWID  in  ID_WIDTH  write ID
S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  beat size (ignored; full width assumed)
S_AXI_AWBURST  in  2  burst type
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BID  out  ID_WIDTH  response ID
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARID  in  ID_WIDTH  read ID
S_AXI_ARADDR  in  ADDR_WIDTH  read start byte address
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARSIZE  in  3  ignored
S_AXI_ARBURST  in  2  burst type
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RID  out  ID_WIDTH  read ID
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Reset (ARESET=1 at edge): both FSMs to IDLE regardless of current state; mid-burst transactions are abandoned.
  - Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0.
  - RAM contents are not cleared.
  - AWREADY/ARREADY are 1 from the first cycle after reset release.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, word address = AWADDR>>log2(DATA_WIDTH/8), beat count = AWLEN; err flag = (AWBURST!=2'b01). Enter W_DATA; AWREADY=0.
  - W_DATA: WREADY=1. On each W handshake, if address is in range and the burst is INCR, write the RAM bytes with WSTRB set. An out-of-range beat sets err and is discarded. Address increments by 1 word per beat; no wrap.
  - WLAST check: the beat counter defines the last beat. WLAST=1 before the last beat, or WLAST=0 on the last beat, sets err. The beat still completes.
  - After the last W handshake: WREADY=0, then W_RESP with BVALID=1 on the next cycle. BRESP=2'b10 (SLVERR) if err, else 2'b00. BID = latched ID. Hold until BREADY; on handshake return to W_IDLE (AWREADY=1 next cycle).
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch ID, address, and length. RDATA is loaded from RAM at that same edge, so RVALID=1 on the next cycle (1-cycle latency).
  - R_DATA: RDATA/RRESP/RLAST held stable while RVALID=1 and RREADY=0. On handshake, the next beat's data is registered at that edge, giving back-to-back beats with no bubble.
  - RLAST=1 on beat ARLEN. After the final handshake: RVALID=0 and return to R_IDLE.
  - Out-of-range beat or non-INCR ARBURST: RDATA=0, RRESP=2'b10 for that beat; other beats OKAY.
- Simultaneous RAM write and read of the same word in one cycle: the read returns the pre-write value.
- AW and AR may be accepted in the same cycle; the channels never stall each other.
- Address bits below beat size are ignored (aligned-only); unaligned start addresses are truncated.

Test Plan:
- Write AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, WSTRB=0xF, BREADY=1 -> BVALID one cycle after the 4th beat, BRESP=0, BID=AWID. Read back ARADDR=0x10, ARLEN=3 -> RDATA 0xA0,0xA1,0xA2,0xA3, RLAST only on 4th beat, RRESP=0.
- Partial strobe: word 0x0 holds 0x11223344; write 0xAABBCCDD with WSTRB=0x5 -> readback 0x11BB33DD.
- Backpressure: RREADY low for 3 cycles mid-burst, BREADY low for 2 cycles -> RDATA/RLAST/BVALID/BRESP held stable; no beat lost or duplicated.
- Out of range: DEPTH=1024, AWADDR=0xFF8, AWLEN=3 -> RAM words 1022/1023 written, others untouched, BRESP=2'b10. Read of the same range -> beats 3,4 RDATA=0 and RRESP=2'b10.
- Protocol errors: AWBURST=2'b00 -> no RAM write, BRESP=2'b10. AWLEN=3 with WLAST on beat 2 -> 4 beats still accepted, BRESP=2'b10.
- Reset mid-burst: assert ARESET after the 2nd of 4 read beats -> next cycle RVALID=0, ARREADY=0. After release, ARREADY=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed RAM; independent write and read FSMs, one burst each.
// B follows the last W beat by one cycle; R data is registered, one cycle after AR, with back-to-back beats.
module axi4_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

  // ---------------- write channel ----------------
  wstate_t                 wstate_q, wstate_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]     bid_q, bid_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]              wcnt_q, wcnt_d;
  logic                    werr_q, werr_d;
  logic                    wbad_q, wbad_d;
  logic                    werr_n;
  logic                    mem_we;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wbad_d    = wbad_q;
    werr_n    = werr_q;
    mem_we    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR >> OFF;
          wcnt_d    = S_AXI_AWLEN;
          wbad_d    = (S_AXI_AWBURST != BURST_INCR);
          werr_d    = (S_AXI_AWBURST != BURST_INCR);
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          if (waddr_q >= DEPTH_A) werr_n = 1'b1;
          else if (!wbad_q)       mem_we = 1'b1;
          // The beat counter, not WLAST, decides where the burst ends.
          if (S_AXI_WLAST != (wcnt_q == 8'd0)) werr_n = 1'b1;
          werr_d  = werr_n;
          waddr_d = waddr_q + ADDR_WIDTH'(1);
          wcnt_d  = wcnt_q - 8'd1;
          if (wcnt_q == 8'd0) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = werr_n ? RESP_ERR : RESP_OK;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      waddr_q   <= '0;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
      wbad_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wbad_q    <= wbad_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[waddr_q[IDX_W-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t                 rstate_q, rstate_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]     rid_q, rid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [7:0]              rlen_q, rlen_d;
  logic [7:0]              rcnt_q, rcnt_d;
  logic                    rbad_q, rbad_d;
  logic                    ar_hs;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_ok;
  logic [DATA_WIDTH-1:0]   rd_word;

  // The RAM is read combinationally and captured at the edge, so a same-cycle write is not seen.
  always_comb begin
    ar_hs   = (rstate_q == R_IDLE) && S_AXI_ARVALID && arready_q;
    rd_addr = ar_hs ? (S_AXI_ARADDR >> OFF) : raddr_q;
    rd_ok   = (rd_addr < DEPTH_A) && (ar_hs ? (S_AXI_ARBURST == BURST_INCR) : !rbad_q);
    rd_word = rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rbad_d    = rbad_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rid_d     = S_AXI_ARID;
          rlen_d    = S_AXI_ARLEN;
          rcnt_d    = 8'd0;
          rbad_d    = (S_AXI_ARBURST != BURST_INCR);
          raddr_d   = rd_addr + ADDR_WIDTH'(1);
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rd_ok ? RESP_OK : RESP_ERR;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            raddr_d = raddr_q + ADDR_WIDTH'(1);
            rdata_d = rd_word;
            rresp_d = rd_ok ? RESP_OK : RESP_ERR;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      rbad_q    <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rbad_q    <= rbad_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, backpressure, range/protocol errors, reset mid-burst.
module tb_axi4_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWID = '0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [2:0]  S_AXI_AWSIZE = 3'd2;
  logic [1:0]  S_AXI_AWBURST = 2'b01;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [3:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARID = '0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_ARSIZE = 3'd2;
  logic [1:0]  S_AXI_ARBURST = 2'b01;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [3:0]  S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wtab  [256];
  logic [31:0] edat  [256];
  logic [1:0]  eresp [256];

  always #5 ACLK = ~ACLK;

  axi4_slave_mem #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [3:0] strb, input int lastpos,
                          input logic [1:0] exp_resp, input int hold);
    int t;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
    S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < 50) begin step(); t++; end
    check("aw_ready", S_AXI_AWREADY, 1);
    step();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      S_AXI_WDATA = wtab[i]; S_AXI_WSTRB = strb;
      S_AXI_WLAST = (i == lastpos); S_AXI_WVALID = 1'b1;
      t = 0;
      while (!S_AXI_WREADY && t < 50) begin step(); t++; end
      check("w_ready", S_AXI_WREADY, 1);
      step();
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    check("w_ready_drop", S_AXI_WREADY, 0);
    check("b_valid_lat", S_AXI_BVALID, 1);
    for (int i = 0; i < hold; i++) begin
      step();
      check("b_hold_valid", S_AXI_BVALID, 1);
      check("b_hold_resp", S_AXI_BRESP, exp_resp);
      check("b_hold_id", S_AXI_BID, id);
    end
    S_AXI_BREADY = 1'b1;
    check("b_resp", S_AXI_BRESP, exp_resp);
    check("b_id", S_AXI_BID, id);
    step();
    S_AXI_BREADY = 1'b0;
    check("b_done", S_AXI_BVALID, 0);
    check("aw_ready_back", S_AXI_AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int ntake, input int stall_at,
                         input int stall_n);
    int t;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
    S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < 50) begin step(); t++; end
    check("ar_ready", S_AXI_ARREADY, 1);
    step();
    S_AXI_ARVALID = 1'b0;
    check("r_latency", S_AXI_RVALID, 1);
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < ntake; i++) begin
      if (i == stall_at) begin
        S_AXI_RREADY = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          step();
          check("r_hold_valid", S_AXI_RVALID, 1);
          check("r_hold_data", S_AXI_RDATA, edat[i]);
          check("r_hold_last", S_AXI_RLAST, (i == len));
        end
        S_AXI_RREADY = 1'b1;
      end
      check("r_valid", S_AXI_RVALID, 1);
      check("r_data", S_AXI_RDATA, edat[i]);
      check("r_resp", S_AXI_RRESP, eresp[i]);
      check("r_last", S_AXI_RLAST, (i == len));
      check("r_id", S_AXI_RID, id);
      step();
    end
    S_AXI_RREADY = 1'b0;
    if (ntake == len + 1) begin
      check("r_done", S_AXI_RVALID, 0);
      check("ar_ready_back", S_AXI_ARREADY, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) step();
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_bresp", S_AXI_BRESP, 0);
    check("rst_bid", S_AXI_BID, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_rlast", S_AXI_RLAST, 0);
    check("rst_rresp", S_AXI_RRESP, 0);
    check("rst_rid", S_AXI_RID, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    ARESET = 1'b0;
    step();
    check("rel_awready", S_AXI_AWREADY, 1);
    check("rel_arready", S_AXI_ARREADY, 1);

    // Basic 4-beat write and readback
    for (int i = 0; i < 4; i++) wtab[i] = 32'hA0 + 32'(i);
    do_write(4'h5, 32'h10, 3, 2'b01, 4'hF, 3, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hA0 + 32'(i); eresp[i] = 2'b00; end
    do_read(4'h3, 32'h10, 3, 2'b01, 4, -1, 0);

    // Partial strobe
    wtab[0] = 32'h11223344;
    do_write(4'h1, 32'h0, 0, 2'b01, 4'hF, 0, 2'b00, 0);
    wtab[0] = 32'hAABBCCDD;
    do_write(4'h2, 32'h0, 0, 2'b01, 4'h5, 0, 2'b00, 0);
    edat[0] = 32'h11BB33DD; eresp[0] = 2'b00;
    do_read(4'h7, 32'h0, 0, 2'b01, 1, -1, 0);

    // Backpressure on B and R
    for (int i = 0; i < 4; i++) wtab[i] = 32'hB0 + 32'(i);
    do_write(4'h9, 32'h40, 3, 2'b01, 4'hF, 3, 2'b00, 2);
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hB0 + 32'(i); eresp[i] = 2'b00; end
    do_read(4'hA, 32'h40, 3, 2'b01, 4, 1, 3);

    // Burst running off the top of the RAM
    for (int i = 0; i < 4; i++) wtab[i] = 32'hC0 + 32'(i);
    do_write(4'h4, 32'hFF8, 3, 2'b01, 4'hF, 3, 2'b10, 0);
    edat[0] = 32'hC0; edat[1] = 32'hC1; edat[2] = 32'h0; edat[3] = 32'h0;
    eresp[0] = 2'b00; eresp[1] = 2'b00; eresp[2] = 2'b10; eresp[3] = 2'b10;
    do_read(4'h6, 32'hFF8, 3, 2'b01, 4, -1, 0);

    // FIXED burst write is discarded; word 0x10 keeps 0xA0
    wtab[0] = 32'hDEAD;
    do_write(4'h8, 32'h10, 0, 2'b00, 4'hF, 0, 2'b10, 0);
    edat[0] = 32'hA0; eresp[0] = 2'b00;
    do_read(4'h8, 32'h10, 0, 2'b01, 1, -1, 0);

    // FIXED burst read returns zero data with SLVERR
    edat[0] = 32'h0; edat[1] = 32'h0; eresp[0] = 2'b10; eresp[1] = 2'b10;
    do_read(4'hB, 32'h10, 1, 2'b00, 2, -1, 0);

    // Early WLAST: all beats still written, SLVERR reported
    for (int i = 0; i < 4; i++) wtab[i] = 32'hD0 + 32'(i);
    do_write(4'hC, 32'h80, 3, 2'b01, 4'hF, 1, 2'b10, 0);
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hD0 + 32'(i); eresp[i] = 2'b00; end
    do_read(4'hD, 32'h80, 3, 2'b01, 4, -1, 0);

    // Reset after the second of four read beats
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hA0 + 32'(i); eresp[i] = 2'b00; end
    do_read(4'hE, 32'h10, 3, 2'b01, 2, -1, 0);
    ARESET = 1'b1;
    step();
    check("mid_rst_rvalid", S_AXI_RVALID, 0);
    check("mid_rst_arready", S_AXI_ARREADY, 0);
    check("mid_rst_rlast", S_AXI_RLAST, 0);
    ARESET = 1'b0;
    step();
    check("post_rst_arready", S_AXI_ARREADY, 1);
    check("post_rst_awready", S_AXI_AWREADY, 1);
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hB0 + 32'(i); eresp[i] = 2'b00; end
    do_read(4'hF, 32'h40, 3, 2'b01, 4, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
